// File: rtl/int_dsp_linklayer_gen.sv
// Multi-channel FPGA->DSP interrupt generator: fixed-width pulses per channel, started by a
// software trigger or by a shared periodic tick, with retrigger policy, polarity and overrun flags.
module int_dsp_linklayer_gen #(
    parameter int N_CH       = 4,
    parameter int PULSE_LEN  = 200000,
    parameter int CNT_W      = 18,
    parameter int PERIOD     = 1562500,
    parameter int PER_W      = 21,
    parameter int RETRIG     = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] trig,
    input  logic [N_CH-1:0] periodic,
    input  logic [N_CH-1:0] clr_ovr,
    output logic [N_CH-1:0] int_out,
    output logic [N_CH-1:0] int_begin,
    output logic            tick,
    output logic [N_CH-1:0] ovr
);

    if ((64'd1 << CNT_W) <= 64'(PULSE_LEN)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for PULSE_LEN");
    end
    if ((64'd1 << PER_W) <= 64'(PERIOD)) begin : g_bad_per_w
        $error("PER_W too narrow for PERIOD");
    end

    localparam logic             POL      = (ACTIVE_LOW != 0);
    localparam logic             RT       = (RETRIG != 0);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] LEN      = CNT_W'(PULSE_LEN);

    typedef enum logic {ST_IDLE, ST_ACTIVE} ch_state_t;

    logic [PER_W-1:0] per_cnt;
    logic             tick_q;

    // Tick is registered off the terminal count, so it lands PERIOD cycles after en rises.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            per_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (per_cnt == PER_LAST);
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             beg_q, beg_d;
        logic             ovr_q, ovr_d;
        logic             start;

        // A trigger coinciding with an enabled tick is one event, not two.
        assign start = trig[i] | (tick_q & periodic[i]);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            beg_d   = 1'b0;
            ovr_d   = clr_ovr[i] ? 1'b0 : ovr_q;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = CNT_W'(1);
                        beg_d   = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (start) begin
                        ovr_d = 1'b1;
                    end
                    if (start && RT) begin
                        cnt_d = CNT_W'(1);
                        beg_d = 1'b1;
                    end else if (cnt_q == LEN) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                beg_q   <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                beg_q   <= beg_d;
                ovr_q   <= ovr_d;
            end
        end

        assign int_out[i]   = (state_q == ST_ACTIVE) ^ POL;
        assign int_begin[i] = beg_q;
        assign ovr[i]       = ovr_q;
    end

endmodule
